// File: rtl/mem_window_router.sv
// Core-side request router: steers one request at a time to local memory or the external bus
// by address window, with an external ack timeout and optional local address rebasing.
module mem_window_router #(
    parameter int unsigned     DATA_W       = 64,
    parameter int unsigned     ADDR_W       = 64,
    parameter longint unsigned WIN_BASE     = 64'd16384,
    parameter longint unsigned WIN_LIMIT    = 64'd20480,
    parameter int unsigned     LOCAL_AW     = 13,
    parameter bit              LOCAL_REBASE = 1'b0,
    parameter int unsigned     TIMEOUT      = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic                core_ready,
    output logic                core_done,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_err,
    output logic                loc_read,
    output logic                loc_write,
    output logic [LOCAL_AW-1:0] loc_addr,
    output logic [DATA_W-1:0]   loc_wdata,
    input  logic [DATA_W-1:0]   loc_rdata,
    output logic                ext_read,
    output logic                ext_write,
    output logic [ADDR_W-1:0]   ext_addr,
    output logic [DATA_W-1:0]   ext_wdata,
    input  logic [DATA_W-1:0]   ext_rdata,
    input  logic                ext_ack
);

    typedef enum logic [2:0] {StIdle, StLocStb, StLocCap, StExtStb, StDone} state_t;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_t              state;
    logic [15:0]         cnt;
    logic                we_q;
    logic                in_win;
    logic [LOCAL_AW-1:0] loc_addr_next;

    assign in_win = (core_addr > ADDR_W'(WIN_BASE)) && (core_addr < ADDR_W'(WIN_LIMIT));

    // Subtracting in LOCAL_AW bits equals the truncated full-width difference.
    assign loc_addr_next = LOCAL_REBASE ? core_addr[LOCAL_AW-1:0] - LOCAL_AW'(WIN_BASE)
                                        : core_addr[LOCAL_AW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            we_q       <= 1'b0;
            core_ready <= 1'b1;
            core_done  <= 1'b0;
            core_rdata <= '0;
            core_err   <= 1'b0;
            loc_read   <= 1'b0;
            loc_write  <= 1'b0;
            loc_addr   <= '0;
            loc_wdata  <= '0;
            ext_read   <= 1'b0;
            ext_write  <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (core_req) begin
                        we_q       <= core_we;
                        core_ready <= 1'b0;
                        cnt        <= '0;
                        if (in_win) begin
                            state     <= StLocStb;
                            loc_read  <= ~core_we;
                            loc_write <= core_we;
                            loc_addr  <= loc_addr_next;
                            loc_wdata <= core_wdata;
                        end else begin
                            state     <= StExtStb;
                            ext_read  <= ~core_we;
                            ext_write <= core_we;
                            ext_addr  <= core_addr;
                            ext_wdata <= core_wdata;
                        end
                    end
                end
                StLocStb: begin
                    state     <= StLocCap;
                    loc_read  <= 1'b0;
                    loc_write <= 1'b0;
                    loc_addr  <= '0;
                    loc_wdata <= '0;
                end
                StLocCap: begin
                    state      <= StDone;
                    core_done  <= 1'b1;
                    core_err   <= 1'b0;
                    core_rdata <= we_q ? '0 : loc_rdata;
                end
                StExtStb: begin
                    // An ack on the last allowed cycle takes priority over the timeout.
                    if (ext_ack || cnt == CntLast) begin
                        state      <= StDone;
                        core_done  <= 1'b1;
                        core_err   <= ~ext_ack;
                        core_rdata <= (ext_ack && !we_q) ? ext_rdata : '0;
                        ext_read   <= 1'b0;
                        ext_write  <= 1'b0;
                        ext_addr   <= '0;
                        ext_wdata  <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StDone: begin
                    state      <= StIdle;
                    cnt        <= '0;
                    core_done  <= 1'b0;
                    core_rdata <= '0;
                    core_err   <= 1'b0;
                    core_ready <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
